// File: rtl/ac_compressor_sequencer.sv
// ac_compressor_sequencer
//
// Sits between the AC mode/temperature controller and the compressor/fan
// drivers. It protects the compressor with a minimum off-time lockout, a
// minimum on-time, a fan pre-run before start and a fan purge after stop.
// While the compressor runs, the fan speed ramps one step at a time.
//
// Every output is a flop. Each flop is loaded from the next-state decode,
// so the outputs always match seq_state in the same cycle.
//
// Optional build macro: AC_SEQ_FAULT_EN adds the comp_fault input and the
// sticky fault_latched output.
module ac_compressor_sequencer #(
  parameter int MIN_OFF_CYCLES = 16,
  parameter int MIN_ON_CYCLES  = 32,
  parameter int PRERUN_CYCLES  = 4,
  parameter int RAMP_CYCLES    = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req_speed,
  input  logic [7:0]       req_heat,
`ifdef AC_SEQ_FAULT_EN
  input  logic             comp_fault,
  output logic             fault_latched,
`endif
  output logic [2:0]       fan_speed_out,
  output logic [7:0]       fan_heat_out,
  output logic             comp_on,
  output logic             busy,
  output logic [2:0]       seq_state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LOCKOUT = 3'd1,
    S_PRERUN  = 3'd2,
    S_RUN     = 3'd3,
    S_PURGE   = 3'd4
  } state_t;

  // Counters are compared against "last cycle" values, so an N-cycle phase
  // ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRERUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;    // phase counter; acts as the on-counter in S_RUN
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [2:0]       fan_q, fan_d;
  logic [7:0]       heat_q, heat_d;
  logic             comp_q, comp_d;
  logic             busy_q, busy_d;
  logic [2:0]       target_s;
  logic             fault_q, fault_d;
  logic             fault_in_s;

`ifdef AC_SEQ_FAULT_EN
  assign fault_in_s = comp_fault;
`else
  assign fault_in_s = 1'b0;
`endif

  // Fan target: the request clamped to 1..4; a zero request ramps down to 1.
  always_comb begin
    target_s = req_speed;
    if (req_speed == 3'd0) begin
      target_s = 3'd1;
    end else if (req_speed > 3'd4) begin
      target_s = 3'd4;
    end else begin
      target_s = req_speed;
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ramp_d  = ramp_q;
    fan_d   = fan_q;
    heat_d  = 8'd0;
    comp_d  = 1'b0;
    busy_d  = 1'b1;
    fault_d = fault_q;

    case (state_q)
      S_LOCKOUT: begin
        if (cnt_q >= OFF_LAST) state_d = S_OFF;
        else                   state_d = S_LOCKOUT;
      end
      S_OFF: begin
        if ((req_speed != 3'd0) && !fault_q) state_d = S_PRERUN;
        else                                 state_d = S_OFF;
      end
      S_PRERUN: begin
        // The compressor never started, so an abort skips the lockout.
        if (req_speed == 3'd0)      state_d = S_OFF;
        else if (cnt_q >= PRE_LAST) state_d = S_RUN;
        else                        state_d = S_PRERUN;
      end
      S_RUN: begin
        if ((req_speed == 3'd0) && (cnt_q >= ON_LAST)) state_d = S_PURGE;
        else                                           state_d = S_RUN;
      end
      S_PURGE: begin
        if (cnt_q >= PRE_LAST) state_d = S_LOCKOUT;
        else                   state_d = S_PURGE;
      end
      default: state_d = S_LOCKOUT;
    endcase

    // A compressor fault bypasses min-on and purge and goes straight to lockout.
    if (fault_in_s && ((state_q == S_PRERUN) || (state_q == S_RUN))) begin
      state_d = S_LOCKOUT;
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end

    // The phase counter restarts on every state change and saturates.
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_d)
      S_RUN: begin
        comp_d = 1'b1;
        heat_d = req_heat;
        if (state_q != S_RUN) begin
          ramp_d = {CNT_W{1'b0}};
          fan_d  = 3'd1;
        end else if (ramp_q >= RAMP_LAST) begin
          ramp_d = {CNT_W{1'b0}};
          if (fan_q < target_s)      fan_d = fan_q + 3'd1;
          else if (fan_q > target_s) fan_d = fan_q - 3'd1;
          else                       fan_d = fan_q;
        end else begin
          ramp_d = ramp_q + CNT_ONE;
        end
      end
      S_PRERUN, S_PURGE: begin
        fan_d  = 3'd1;
        ramp_d = {CNT_W{1'b0}};
      end
      S_OFF: begin
        fan_d  = 3'd0;
        busy_d = 1'b0;
        ramp_d = {CNT_W{1'b0}};
      end
      default: begin
        fan_d  = 3'd0;
        ramp_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and output registers; reset starts a full lockout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOCKOUT;
      cnt_q   <= {CNT_W{1'b0}};
      ramp_q  <= {CNT_W{1'b0}};
      fan_q   <= 3'd0;
      heat_q  <= 8'd0;
      comp_q  <= 1'b0;
      busy_q  <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      fan_q   <= fan_d;
      heat_q  <= heat_d;
      comp_q  <= comp_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign fan_speed_out = fan_q;
  assign fan_heat_out  = heat_q;
  assign comp_on       = comp_q;
  assign busy          = busy_q;
  assign seq_state     = state_q;

`ifdef AC_SEQ_FAULT_EN
  assign fault_latched = fault_q;
`endif

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Directed bench for ac_compressor_sequencer: a table of constant-input
// segments, each checked on every cycle, plus hand sequences for heat
// latency, mid-run asynchronous reset and (with AC_SEQ_FAULT_EN) faults.
module tb_ac_compressor_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] req_speed;
  logic [7:0] req_heat;
  logic [2:0] fan_speed_out;
  logic [7:0] fan_heat_out;
  logic       comp_on;
  logic       busy;
  logic [2:0] seq_state;
`ifdef AC_SEQ_FAULT_EN
  logic       comp_fault;
  logic       fault_latched;
`endif

  int checks;
  int errors;

  ac_compressor_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req_speed     (req_speed),
    .req_heat      (req_heat),
`ifdef AC_SEQ_FAULT_EN
    .comp_fault    (comp_fault),
    .fault_latched (fault_latched),
`endif
    .fan_speed_out (fan_speed_out),
    .fan_heat_out  (fan_heat_out),
    .comp_on       (comp_on),
    .busy          (busy),
    .seq_state     (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] spd;
    int         n;
    logic [2:0] st;
    logic [2:0] fan;
    logic       comp;
    logic       bsy;
  } seg_t;

  seg_t tbl[35];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; each cycle is sampled on the falling edge.
  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      req_speed = tbl[i].spd;
      for (int c = 0; c < tbl[i].n; c++) begin
        @(negedge clk);
        chk($sformatf("seg%0d.c%0d.state", i, c), 32'(seq_state), 32'(tbl[i].st));
        chk($sformatf("seg%0d.c%0d.fan", i, c), 32'(fan_speed_out), 32'(tbl[i].fan));
        chk($sformatf("seg%0d.c%0d.comp", i, c), 32'(comp_on), 32'(tbl[i].comp));
        chk($sformatf("seg%0d.c%0d.busy", i, c), 32'(busy), 32'(tbl[i].bsy));
        chk($sformatf("seg%0d.c%0d.heat", i, c), 32'(fan_heat_out),
            tbl[i].comp ? 32'h15 : 32'h0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // First run: lockout, off, prerun, ramp 1->2->3, then stop past min-on.
    tbl[0]  = '{3'd3, 16, 3'd1, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{3'd3,  1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{3'd3,  4, 3'd2, 3'd1, 1'b0, 1'b1};
    tbl[3]  = '{3'd3,  8, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[4]  = '{3'd3,  8, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[5]  = '{3'd3, 20, 3'd3, 3'd3, 1'b1, 1'b1};
    tbl[6]  = '{3'd0,  1, 3'd3, 3'd3, 1'b1, 1'b1};
    tbl[7]  = '{3'd0,  4, 3'd4, 3'd1, 1'b0, 1'b1};
    // Request 2 during lockout is only honoured once in S_OFF.
    tbl[8]  = '{3'd2, 16, 3'd1, 3'd0, 1'b0, 1'b1};
    tbl[9]  = '{3'd2,  1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{3'd2,  4, 3'd2, 3'd1, 1'b0, 1'b1};
    // Early stop at on-count 10: hold RUN until on-count 32, ramp toward 1.
    tbl[11] = '{3'd2,  8, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[12] = '{3'd2,  2, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[13] = '{3'd0,  6, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[14] = '{3'd0, 16, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[15] = '{3'd0,  4, 3'd4, 3'd1, 1'b0, 1'b1};
    // Second run: stop cancelled at on-count 20 with an over-range request.
    tbl[16] = '{3'd4, 16, 3'd1, 3'd0, 1'b0, 1'b1};
    tbl[17] = '{3'd4,  1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[18] = '{3'd4,  4, 3'd2, 3'd1, 1'b0, 1'b1};
    tbl[19] = '{3'd4,  8, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[20] = '{3'd4,  2, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[21] = '{3'd0,  6, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[22] = '{3'd0,  4, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[23] = '{3'd7,  4, 3'd3, 3'd1, 1'b1, 1'b1};
    tbl[24] = '{3'd7,  8, 3'd3, 3'd2, 1'b1, 1'b1};
    tbl[25] = '{3'd7,  8, 3'd3, 3'd3, 1'b1, 1'b1};
    tbl[26] = '{3'd7, 12, 3'd3, 3'd4, 1'b1, 1'b1};
    // After mid-run reset: full lockout, prerun abort, restart at speed 1.
    tbl[27] = '{3'd7, 16, 3'd1, 3'd0, 1'b0, 1'b1};
    tbl[28] = '{3'd7,  1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[29] = '{3'd7,  2, 3'd2, 3'd1, 1'b0, 1'b1};
    tbl[30] = '{3'd0,  1, 3'd2, 3'd1, 1'b0, 1'b1};
    tbl[31] = '{3'd0,  3, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[32] = '{3'd1,  1, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[33] = '{3'd1,  4, 3'd2, 3'd1, 1'b0, 1'b1};
    tbl[34] = '{3'd1,  3, 3'd3, 3'd1, 1'b1, 1'b1};

    reset     = 1'b1;
    req_speed = 3'd3;
    req_heat  = 8'h15;
`ifdef AC_SEQ_FAULT_EN
    comp_fault = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(seq_state), 32'd1);
    chk("rst.fan", 32'(fan_speed_out), 32'd0);
    chk("rst.comp", 32'(comp_on), 32'd0);
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.heat", 32'(fan_heat_out), 32'd0);
`ifdef AC_SEQ_FAULT_EN
    chk("rst.fault", 32'(fault_latched), 32'd0);
`endif
    reset = 1'b0;

    run_segs(0, 26);

    // Heat code follows req_heat with one cycle of latency while running.
    req_heat = 8'hA5;
    @(negedge clk);
    chk("heat.before", 32'(fan_heat_out), 32'h15);
    @(posedge clk);
    #1;
    chk("heat.after", 32'(fan_heat_out), 32'hA5);
    chk("prerst.state", 32'(seq_state), 32'd3);
    chk("prerst.fan", 32'(fan_speed_out), 32'd4);
    req_heat = 8'h15;

    // Asynchronous reset mid-run takes effect without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("arst.state", 32'(seq_state), 32'd1);
    chk("arst.fan", 32'(fan_speed_out), 32'd0);
    chk("arst.comp", 32'(comp_on), 32'd0);
    chk("arst.busy", 32'(busy), 32'd1);
    chk("arst.heat", 32'(fan_heat_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_segs(27, 34);

`ifdef AC_SEQ_FAULT_EN
    // Fault in RUN: straight to lockout, sticky latch, and no restart.
    req_speed  = 3'd2;
    comp_fault = 1'b1;
    @(posedge clk);
    #1;
    comp_fault = 1'b0;
    chk("flt.state", 32'(seq_state), 32'd1);
    chk("flt.comp", 32'(comp_on), 32'd0);
    chk("flt.fan", 32'(fan_speed_out), 32'd0);
    chk("flt.latch", 32'(fault_latched), 32'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("flt.lock%0d", k), 32'(seq_state), 32'd1);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("flt.off%0d.state", k), 32'(seq_state), 32'd0);
      chk($sformatf("flt.off%0d.latch", k), 32'(fault_latched), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
